mdio_master: RTL and testbench

- Parametrised MDIO management master driving the PHY MDC/MDIO pins through the top-level IOBUF (mdio_o / mdio_t / mdio_i).
- Generalises the fixed management path of the SGMII PCS core:
  - configurable MDC divider and preamble length;
  - per-command preamble suppression;
  - Clause 22 and optional Clause 45 frames;
  - read turnaround checking.
- Accepts one command at a time via valid/ready and returns a single-cycle response.

---
 rtl/mdio_master.sv | 185 ++++++++++++++++++
 tb/tb_mdio_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master - parametrised MDIO (IEEE 802.3 Clause 22/45) management master.
//   Accepts one command at a time over a valid/ready handshake, serialises the
//   frame on MDC/MDIO via an external IOBUF and returns a one-cycle response.
// Parameters:
//   CLK_DIV     clk cycles per MDC half-period (>= 2)
//   PRE_LEN     preamble length in bits
//   C45_EN      non-zero enables Clause 45 frames
//   SYNC_STAGES flops in the mdio_i synchroniser
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_c45, cmd_op, cmd_nopre, cmd_phyad, cmd_regad, cmd_wdata  command fields
//   rsp_valid, rsp_rdata, rsp_err   response (data/err held until next pulse)
//   busy                 transaction in progress
//   mdc, mdio_o, mdio_t, mdio_i     PHY management pins (mdio_t=1 releases)
module mdio_master #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned PRE_LEN     = 32,
  parameter int unsigned C45_EN      = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_nopre,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(((PRE_LEN > 32) ? PRE_LEN : 32) + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'((PRE_LEN > 0) ? (PRE_LEN - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_DONE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          div_q;
  logic [BW-1:0]          bit_q;
  logic [31:0]            frame_q;
  logic [15:0]            rdata_q;
  logic                   rd_q, ta_err_q;
  logic                   cmd_ready_q, busy_q, rsp_valid_q, rsp_err_q;
  logic [15:0]            rsp_rdata_q;
  logic                   mdc_q, mdio_o_q, mdio_t_q;

  logic        mdio_s;
  logic        cmd_rd, cmd_legal, cmd_pre;
  logic [31:0] cmd_frame;

  assign mdio_s    = sync_q[SYNC_STAGES-1];
  // C45 ops 10 (read-increment) and 11 (read) both turn the bus around.
  assign cmd_rd    = cmd_c45 ? cmd_op[1] : (cmd_op == 2'b10);
  assign cmd_legal = cmd_c45 ? (C45_EN != 0) : ((cmd_op == 2'b01) || (cmd_op == 2'b10));
  assign cmd_pre   = !cmd_nopre && (PRE_LEN != 0);
  assign cmd_frame = {(cmd_c45 ? 2'b00 : 2'b01), cmd_op, cmd_phyad, cmd_regad,
                      2'b10, cmd_wdata};

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '1;
      div_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
      ta_err_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
    end else begin
      sync_q[0] <= mdio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rd_q        <= cmd_rd;
            frame_q     <= cmd_frame;
            div_q       <= '0;
            bit_q       <= '0;
            rdata_q     <= '0;
            ta_err_q    <= 1'b0;
            if (!cmd_legal) begin
              // Rejected without touching the bus: respond on the next cycle.
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              mdc_q    <= 1'b0;
              mdio_t_q <= 1'b0;
              if (cmd_pre) begin
                state_q  <= S_PRE;
                mdio_o_q <= 1'b1;
              end else begin
                state_q  <= S_FRAME;
                mdio_o_q <= cmd_frame[31];
              end
            end
          end
        end

        S_PRE, S_FRAME: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!mdc_q) begin
              // Rising MDC: sample the synchronised line for read frames.
              mdc_q <= 1'b1;
              if (state_q == S_FRAME && rd_q) begin
                if (bit_q == BW'(15)) ta_err_q <= mdio_s;
                if (bit_q >= BW'(16)) rdata_q <= {rdata_q[14:0], mdio_s};
              end
            end else begin
              // End of a bit period: falling MDC, present the next bit.
              mdc_q <= 1'b0;
              if (state_q == S_PRE) begin
                if (bit_q == PRE_LAST) begin
                  state_q  <= S_FRAME;
                  bit_q    <= '0;
                  mdio_o_q <= frame_q[31];
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end else if (bit_q == BW'(31)) begin
                state_q     <= S_DONE;
                mdio_t_q    <= 1'b1;
                mdio_o_q    <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rd_q ? rdata_q : 16'h0000;
                rsp_err_q   <= rd_q & ta_err_q;
              end else begin
                bit_q    <= bit_q + 1'b1;
                frame_q  <= {frame_q[30:0], 1'b1};
                mdio_o_q <= frame_q[30];
                // Bit 14 is the first turnaround bit: release for reads.
                if (rd_q && bit_q == BW'(13)) mdio_t_q <= 1'b1;
              end
            end
          end
        end

        default: begin  // S_DONE
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master - directed self-checking bench for mdio_master (CLK_DIV=2).
//   dut  : C45_EN=1, dut2 : C45_EN=0 (only used for the illegal C45 case).
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic        cmd_c45 = 1'b0, cmd_nopre = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_phyad = '0, cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i = 1'b1;

  logic        cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_t;
  logic [15:0] rsp_rdata;
  logic        cmd_ready2, rsp_valid2, rsp_err2, busy2, mdc2, mdio_o2, mdio_t2;
  logic [15:0] rsp_rdata2;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PRE_LEN(32), .C45_EN(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_nopre(cmd_nopre),
    .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i));

  mdio_master #(.CLK_DIV(2), .PRE_LEN(32), .C45_EN(0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_nopre(cmd_nopre),
    .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
    .mdc(mdc2), .mdio_o(mdio_o2), .mdio_t(mdio_t2), .mdio_i(mdio_i));

  // Selected-DUT view
  logic        sel = 1'b0;
  logic        o_ready, o_rv, o_err, o_busy, o_mdc, o_mo, o_mt;
  logic [15:0] o_rdata;
  assign o_ready = sel ? cmd_ready2 : cmd_ready;
  assign o_rv    = sel ? rsp_valid2 : rsp_valid;
  assign o_err   = sel ? rsp_err2   : rsp_err;
  assign o_busy  = sel ? busy2      : busy;
  assign o_mdc   = sel ? mdc2       : mdc;
  assign o_mo    = sel ? mdio_o2    : mdio_o;
  assign o_mt    = sel ? mdio_t2    : mdio_t;
  assign o_rdata = sel ? rsp_rdata2 : rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last run_cmd
  int          r_lat, r_rises;
  logic [15:0] r_rdata;
  logic        r_err, r_busy1, r_ready1, r_ready_after, r_end_mdc, r_end_t, r_end_o, r_t_hi;
  logic [63:0] r_so, r_st;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one command on the selected DUT and act as the PHY. phy_bits holds
  // {TA0, DATA[15:0]}; each bit is presented after the preceding MDC rise.
  task automatic run_cmd(input logic s, input logic c45, input logic [1:0] op,
                         input logic nopre, input logic [4:0] phyad,
                         input logic [4:0] regad, input logic [15:0] wdata,
                         input logic phy_en, input logic [16:0] phy_bits);
    int cyc, pre_n, nb;
    logic prev;
    sel = s;
    wait_ready();
    cmd_c45 = c45; cmd_op = op; cmd_nopre = nopre;
    cmd_phyad = phyad; cmd_regad = regad; cmd_wdata = wdata;
    if (s) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cyc = 1; prev = 1'b0; pre_n = nopre ? 0 : 32;
    r_lat = -1; r_rises = 0; r_so = '0; r_st = '0; r_t_hi = 1'b0;
    r_busy1 = o_busy; r_ready1 = o_ready;
    while (cyc <= 3000) begin
      if (o_mdc && !prev) begin
        r_rises++;
        r_so = {r_so[62:0], o_mo};
        r_st = {r_st[62:0], o_mt};
        nb = r_rises - pre_n;  // frame index of the next bit
        if (phy_en && nb == 15) mdio_i = phy_bits[16];
        else if (phy_en && nb >= 16 && nb <= 31) mdio_i = phy_bits[31-nb];
        else mdio_i = 1'b1;
      end
      prev = o_mdc;
      if (o_rv) begin
        r_lat = cyc; r_rdata = o_rdata; r_err = o_err;
        r_end_mdc = o_mdc; r_end_t = o_mt; r_end_o = o_mo;
        break;
      end
      r_t_hi |= o_mt;
      @(negedge clk);
      cyc++;
    end
    mdio_i = 1'b1;
    @(negedge clk);
    r_ready_after = o_ready;
  endtask

  initial begin
    int rises, seen;
    logic prev;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_mdc",       64'(mdc),       64'd0);
    check("rst_mdio_o",    64'(mdio_o),    64'd1);
    check("rst_mdio_t",    64'(mdio_t),    64'd1);
    reset = 1'b0;
    @(negedge clk);

    // 1: C22 write with preamble
    run_cmd(1'b0, 1'b0, 2'b01, 1'b0, 5'd7, 5'd0, 16'h1140, 1'b0, 17'h0);
    check("wr_latency",  64'(r_lat),   64'd257);
    check("wr_busy1",    64'(r_busy1), 64'd1);
    check("wr_ready1",   64'(r_ready1), 64'd0);
    check("wr_rises",    64'(r_rises), 64'd64);
    check("wr_preamble", 64'(r_so[63:32]), 64'hFFFF_FFFF);
    check("wr_frame",    64'(r_so[31:0]),  64'h5382_1140);
    check("wr_t_rise",   r_st, 64'd0);
    check("wr_t_hi",     64'(r_t_hi), 64'd0);
    check("wr_err",      64'(r_err),   64'd0);
    check("wr_rdata",    64'(r_rdata), 64'd0);
    check("wr_end_mdc",  64'(r_end_mdc), 64'd0);
    check("wr_end_t",    64'(r_end_t),   64'd1);
    check("wr_end_o",    64'(r_end_o),   64'd1);
    check("wr_ready_after", 64'(r_ready_after), 64'd1);

    // 2: C22 read, PHY returns 0x0141
    run_cmd(1'b0, 1'b0, 2'b10, 1'b0, 5'd7, 5'd2, 16'h0000, 1'b1, {1'b0, 16'h0141});
    check("rd_latency", 64'(r_lat), 64'd257);
    check("rd_hdr",     64'(r_so[31:18]), 64'(14'b01100011100010));
    check("rd_t_rise",  r_st, 64'h0000_0000_0003_FFFF);
    check("rd_rdata",   64'(r_rdata), 64'h0141);
    check("rd_err",     64'(r_err), 64'd0);

    // 3: C22 read, no PHY (pull-up)
    run_cmd(1'b0, 1'b0, 2'b10, 1'b0, 5'd7, 5'd2, 16'h0000, 1'b0, 17'h0);
    check("nophy_rdata", 64'(r_rdata), 64'hFFFF);
    check("nophy_err",   64'(r_err), 64'd1);

    // Response hold: still visible several cycles later
    repeat (5) @(negedge clk);
    check("hold_rdata", 64'(rsp_rdata), 64'hFFFF);
    check("hold_err",   64'(rsp_err), 64'd1);

    // 5a: C22 op=00 illegal
    run_cmd(1'b0, 1'b0, 2'b00, 1'b0, 5'd7, 5'd0, 16'h0000, 1'b0, 17'h0);
    check("ill22_latency", 64'(r_lat), 64'd1);
    check("ill22_err",     64'(r_err), 64'd1);
    check("ill22_rdata",   64'(r_rdata), 64'd0);
    check("ill22_rises",   64'(r_rises), 64'd0);
    check("ill22_ready1",  64'(r_ready1), 64'd0);
    check("ill22_ready2",  64'(r_ready_after), 64'd1);

    // 5b: C45 on a C45_EN=0 instance
    run_cmd(1'b1, 1'b1, 2'b00, 1'b1, 5'd3, 5'd1, 16'h0008, 1'b0, 17'h0);
    check("ill45_latency", 64'(r_lat), 64'd1);
    check("ill45_err",     64'(r_err), 64'd1);
    check("ill45_mdc",     64'(r_end_mdc), 64'd0);
    check("ill45_rises",   64'(r_rises), 64'd0);
    check("ill45_ready2",  64'(r_ready_after), 64'd1);

    // 4: C45 address then C45 read, no preamble
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 5'd3, 5'd1, 16'h0008, 1'b0, 17'h0);
    check("c45a_latency", 64'(r_lat), 64'd129);
    check("c45a_rises",   64'(r_rises), 64'd32);
    check("c45a_frame",   64'(r_so[31:0]), 64'h0186_0008);
    check("c45a_t_rise",  64'(r_st[31:0]), 64'd0);
    check("c45a_err",     64'(r_err), 64'd0);
    run_cmd(1'b0, 1'b1, 2'b11, 1'b1, 5'd3, 5'd1, 16'h0000, 1'b1, {1'b0, 16'hABCD});
    check("c45r_latency", 64'(r_lat), 64'd129);
    check("c45r_hdr",     64'(r_so[31:18]), 64'(14'b00110001100001));
    check("c45r_t_rise",  64'(r_st[31:0]), 64'h0003_FFFF);
    check("c45r_rdata",   64'(r_rdata), 64'hABCD);
    check("c45r_err",     64'(r_err), 64'd0);

    // 6: reset at bit 40 of a C22 read
    sel = 1'b0;
    wait_ready();
    cmd_c45 = 1'b0; cmd_op = 2'b10; cmd_nopre = 1'b0;
    cmd_phyad = 5'd7; cmd_regad = 5'd2; cmd_wdata = '0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 1000 && rises < 41; n++) begin
      if (mdc && !prev) rises++;
      prev = mdc;
      if (rises < 41) @(negedge clk);
    end
    check("mid_reached_bit40", 64'(rises), 64'd41);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_mdc",       64'(mdc), 64'd0);
    check("mid_mdio_t",    64'(mdio_t), 64'd1);
    check("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_busy",      64'(busy), 64'd0);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", 64'(seen), 64'd0);
    run_cmd(1'b0, 1'b0, 2'b01, 1'b0, 5'd7, 5'd0, 16'h1140, 1'b0, 17'h0);
    check("post_latency", 64'(r_lat), 64'd257);
    check("post_frame",   64'(r_so[31:0]), 64'h5382_1140);
    check("post_err",     64'(r_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
